// File: rtl/serial_bit_source.sv
// serial_bit_source
//   Parallel-to-serial stage feeding the serial pattern detector. Words arrive
//   over a valid/ready handshake into a one-word holding buffer. A shift
//   register then emits them one bit per bit_en cycle on x. Because the buffer
//   reloads the shifter on the edge that consumes the last bit, consecutive
//   words stream with no gap between them.
//
//   State table:
//     IDLE  | shifter empty; loads the buffer on the next edge if it is full
//     SHIFT | x carries a real bit; advances only when bit_en=1
//
// Parameters
//   WIDTH     word width in bits (>= 2)
//   MSB_FIRST 1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   in_data   parallel word to serialize
//   in_valid  in_data is valid this cycle
//   in_ready  holding buffer can take a word (registered, no path from inputs)
//   bit_en    downstream pacing; the shifter advances only when high
//   x         current serial bit (0 when x_valid=0)
//   x_valid   x carries a real bit
//   x_last    x is the final bit of the current word
//   busy      shifter active or holding buffer occupied
module serial_bit_source #(
    parameter int          WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             bit_en,
    output logic             x,
    output logic             x_valid,
    output logic             x_last,
    output logic             busy
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept;
    logic             last_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
        end
    end

    // in_ready is forced low while reset is held so nothing is accepted then.
    assign in_ready = rst && !hold_full_q;
    assign accept   = in_valid && in_ready;
    assign last_bit = (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;

        // A write needs hold_full=0 and a load needs hold_full=1, so the two
        // updates of hold_full_d below never collide on the same edge.
        if (accept) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_en) begin
                    if (!last_bit) begin
                        if (MSB_FIRST != 0) shift_d = {shift_q[WIDTH-2:0], 1'b0};
                        else                shift_d = {1'b0, shift_q[WIDTH-1:1]};
                        cnt_d = cnt_q + CW'(1);
                    end else if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        cnt_d       = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        x_valid = (state_q == SHIFT);
        x       = 1'b0;
        if (x_valid) x = (MSB_FIRST != 0) ? shift_q[WIDTH-1] : shift_q[0];
        x_last  = x_valid && last_bit;
        busy    = x_valid || hold_full_q;
    end

endmodule

// File: tb/tb_serial_bit_source.sv
module tb_serial_bit_source;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         bit_en;

    logic m_ready, m_x, m_xv, m_xl, m_busy;
    logic l_ready, l_x, l_xv, l_xl, l_busy;

    int checks = 0;
    int errors = 0;

    // Reference model: the word in flight is kept as a queue of bits still to
    // be sent (front = bit on x now), one queue per bit order.
    bit           mq[$];
    bit           lq[$];
    bit           mod_full;
    logic [W-1:0] mod_hold;

    always #5 clk = ~clk;

    serial_bit_source #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(m_ready), .bit_en(bit_en), .x(m_x), .x_valid(m_xv),
        .x_last(m_xl), .busy(m_busy)
    );

    serial_bit_source #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(l_ready), .bit_en(bit_en), .x(l_x), .x_valid(l_xv),
        .x_last(l_xl), .busy(l_busy)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic ev, er;
        ev = (mq.size() > 0);
        er = rst && !mod_full;
        chk("msb_in_ready", m_ready, er);
        chk("msb_x_valid",  m_xv,    ev);
        chk("msb_x",        m_x,     ev ? logic'(mq[0]) : 1'b0);
        chk("msb_x_last",   m_xl,    mq.size() == 1);
        chk("msb_busy",     m_busy,  ev || mod_full);
        chk("lsb_in_ready", l_ready, er);
        chk("lsb_x_valid",  l_xv,    lq.size() > 0);
        chk("lsb_x",        l_x,     (lq.size() > 0) ? logic'(lq[0]) : 1'b0);
        chk("lsb_x_last",   l_xl,    lq.size() == 1);
        chk("lsb_busy",     l_busy,  (lq.size() > 0) || mod_full);
    endtask

    task automatic model_reset();
        mq.delete();
        lq.delete();
        mod_full = 1'b0;
        mod_hold = '0;
    endtask

    task automatic model_load();
        mq.delete();
        lq.delete();
        for (int i = W - 1; i >= 0; i--) mq.push_back(mod_hold[i]);
        for (int i = 0; i < W; i++)      lq.push_back(mod_hold[i]);
        mod_full = 1'b0;
    endtask

    // One clock edge worth of behaviour; returns whether the word was taken.
    task automatic model_edge(input logic v, input logic [W-1:0] d, input logic en,
                              output bit acc);
        bit active, rdy;
        active = (mq.size() > 0);
        rdy    = !mod_full;
        if (active && en) begin
            void'(mq.pop_front());
            void'(lq.pop_front());
        end
        if (mod_full && (!active || (en && mq.size() == 0))) model_load();
        acc = v && rdy;
        if (acc) begin
            mod_hold = d;
            mod_full = 1'b1;
        end
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic en,
                        output bit acc);
        in_valid = v;
        in_data  = d;
        bit_en   = en;
        @(posedge clk);
        model_edge(v, d, en, acc);
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic pace(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 3) == 0;
            default: return $urandom_range(0, 3) != 0;
        endcase
    endfunction

    // Holds in_valid high, changing in_data only after acceptance, then drains.
    task automatic send_words(input logic [W-1:0] words[$], input int mode);
        int idx = 0;
        int cyc = 0;
        bit acc;
        while (idx < words.size() && cyc < 400) begin
            step(1'b1, words[idx], pace(mode, cyc), acc);
            if (acc) idx++;
            cyc++;
        end
        chk("send_within_budget", cyc < 400, 1'b1);
        cyc = 0;
        while ((mq.size() > 0 || mod_full) && cyc < 400) begin
            step(1'b0, logic'($urandom) ? 8'hFF : 8'h00, pace(mode, cyc), acc);
            cyc++;
        end
        chk("drain_within_budget", cyc < 400, 1'b1);
        step(1'b0, 8'h00, 1'b1, acc);
    endtask

    initial begin
        logic [W-1:0] words[$];
        bit acc;
        int guard;

        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        bit_en   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b1;
        @(negedge clk);
        check_outputs();

        // Single word, MSB 0x36 / LSB order on the same data.
        words = '{8'h36};
        send_words(words, 0);

        // Back-to-back words, second offered immediately.
        words = '{8'hA5, 8'h3C};
        send_words(words, 0);

        words = '{8'h01};
        send_words(words, 0);

        // Paced by 1,0,0 bit_en pattern.
        words = '{8'hF0};
        send_words(words, 1);

        // Asynchronous reset mid-word with the buffer full.
        step(1'b1, 8'hC3, 1'b1, acc);
        guard = 0;
        do begin
            step(1'b1, 8'h5A, 1'b1, acc);
            guard++;
        end while (!acc && guard < 20);
        guard = 0;
        while (mq.size() != 4 && guard < 20) begin
            step(1'b0, 8'h00, 1'b1, acc);
            guard++;
        end
        chk("reached_bit4", mq.size() == 4, 1'b1);
        chk("buffer_full_before_reset", m_busy && !m_ready, 1'b1);
        #2 rst = 1'b0;
        model_reset();
        #1 check_outputs();
        @(negedge clk);
        rst = 1'b1;
        #1 check_outputs();
        words = '{8'h81};
        send_words(words, 0);

        // Continuous in_valid over four words.
        words = '{8'h12, 8'hED, 8'h7E, 8'h99};
        send_words(words, 0);
        words = '{8'h4B, 8'hC6, 8'h2D};
        send_words(words, 2);

        // Free-running random traffic.
        for (int i = 0; i < 600; i++) begin
            step(logic'($urandom_range(0, 1)), W'($urandom), $urandom_range(0, 3) != 0, acc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_bit_source.md
Name: serial_bit_source

Overview:
- Parallel-to-serial stage directly upstream of the serial pattern detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per enabled cycle on x, with an accompanying x_valid.
- A one-word holding buffer sits in front of the shift register, so consecutive words stream with no bubble between them.

Parameters:
- WIDTH, 8: word width in bits; must be at least 2.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset. 0 = reset asserted.
- in_data  in  WIDTH  parallel word to serialize.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  holding buffer can take a word this cycle.
- bit_en  in  1  downstream pacing; the shifter advances only on cycles where bit_en=1.
- x  out  1  current serial bit; drives the detector input.
- x_valid  out  1  x carries a real bit this cycle.
- x_last  out  1  x is the final bit of the current word.
- busy  out  1  shifter active or holding buffer occupied.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; hold_full=0; shift register, bit counter and holding buffer are cleared.
  - Outputs: x=0, x_valid=0, x_last=0, busy=0, in_ready=0.
  - Reset asserted mid-word discards all in-flight data. No partial word is resumed.
- After reset releases: in_ready = !hold_full, taken from registers only; there is no combinational path from in_valid or bit_en.
- Handshake:
  - A word is accepted on any edge where in_valid=1 and in_ready=1. in_data is then captured into the holding buffer and hold_full is set.
  - in_valid=1 with in_ready=0 has no effect; the source must hold the word until it is accepted.
- State machine, states IDLE and SHIFT:
  - IDLE, hold_full=1: on the next edge, load the buffer into the shifter, clear hold_full, set cnt=0, go to SHIFT. This happens regardless of bit_en.
  - IDLE, hold_full=0: stay in IDLE.
  - SHIFT, bit_en=0: hold everything. x is stable and counts as the same bit.
  - SHIFT, bit_en=1, cnt<WIDTH-1: shift one position toward the output end and increment cnt.
  - SHIFT, bit_en=1, cnt=WIDTH-1, hold_full=1: reload from the buffer, clear hold_full, set cnt=0, stay in SHIFT. No gap cycle.
  - SHIFT, bit_en=1, cnt=WIDTH-1, hold_full=0: go to IDLE.
- Loading and writing the buffer on the same edge is impossible: a write requires hold_full=0, a load requires hold_full=1.
- Outputs:
  - x_valid = (state==SHIFT).
  - x = shifter MSB when MSB_FIRST=1, else shifter LSB. x=0 when x_valid=0.
  - x_last = x_valid && cnt==WIDTH-1.
  - busy = x_valid || hold_full.
- Latency:
  - Word accepted at edge N while IDLE: first bit valid after edge N+1.
  - One bit is consumed per cycle with bit_en=1.
  - Sustained throughput is 1 word per WIDTH enabled cycles.
- Counter width is clog2(WIDTH). cnt never exceeds WIDTH-1 and does not wrap.
- Underrun (buffer empty when the last bit is consumed): x_valid drops to 0 for at least one cycle. This is not an error.
- The detector sees x only; the integration drives the detector's clock-enable from x_valid && bit_en.

Test Plan:
- Single word, WIDTH=8, MSB_FIRST=1, in_data=8'h36 accepted at edge 0, bit_en=1 → x_valid=1 from edge 1; x=0,0,1,1,0,1,1,0 on 8 cycles; x_last high on the 8th; x_valid=0 and busy=0 after edge 9.
- Back-to-back, 8'hA5 then 8'h3C, second word offered at once → in_ready=0 while buffer full; 16 contiguous x_valid cycles; x=10100101 00111100; x_last high on cycles 8 and 16.
- MSB_FIRST=0, in_data=8'h01 → x=1 then seven 0s.
- bit_en toggled 1,0,0,1,… during 8'hF0 → x holds during bit_en=0 cycles; exactly 8 enabled cycles per word; x_last only with the final enabled bit.
- Reset pulse (rst=0) asynchronously mid-word at bit 4, buffer full → all outputs 0 immediately, without waiting for a clock edge; after release in_ready=1, x_valid=0; the next word 8'h81 serializes fully and correctly.
- in_valid=1 held continuously with in_data changing only on acceptance → no word lost or duplicated over 4 words; busy deasserts exactly one cycle after the final x_last with bit_en=1.
